// File: rtl/cpu_pkg.sv
// Shared CPU-front-end types: fetch FSM states, instruction word, memory timing.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    ISSUE = 2'd3
  } fetch_state_t;

  typedef logic [31:0] inst_word_t;

  // Cycles from imem_en to imem_rdata being valid.
  localparam int IMEM_RD_LATENCY = 1;

endpackage

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the pc, reads the instruction memory and
// hands one word at a time to decode, tagged with its pc, pc+1 and epoch.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no fetch in flight; waits for run
//   REQ   | imem read issued at fetch_pc; pc/epoch of the request latched
//   WAIT  | read data arrives; captured into the output word registers
//   ISSUE | word presented to decode (inst_enable); held while stall_in
//
// A redirect from execute wins over normal sequencing in every state: it
// reloads fetch_pc, flips the epoch and restarts at REQ (IDLE only leaves
// when run is set). Words already visible are never retracted; decode drops
// wrong-path words by comparing distinct with its own epoch.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int                        INST_MEM_WIDTH = 2,
  parameter logic [INST_MEM_WIDTH-1:0] RESET_PC       = '0
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      run,
  input  logic                      stall_in,
  input  logic                      redirect_valid,
  input  logic [INST_MEM_WIDTH-1:0] redirect_pc,
  output logic                      imem_en,
  output logic [INST_MEM_WIDTH-1:0] imem_addr,
  input  inst_word_t                imem_rdata,
  output logic                      inst_enable,
  output inst_word_t                inst,
  output logic [INST_MEM_WIDTH-1:0] pc,
  output logic [INST_MEM_WIDTH-1:0] pc1,
  output logic                      distinct
);

  fetch_state_t              state;
  fetch_state_t              state_nxt;
  logic [INST_MEM_WIDTH-1:0] fetch_pc;
  logic                      epoch;
  logic [INST_MEM_WIDTH-1:0] req_pc;
  logic                      req_epoch;
  logic [INST_MEM_WIDTH-1:0] req_pc_inc;
  logic                      req_latch;
  logic                      capture;

  // Wraps naturally at 2^INST_MEM_WIDTH.
  assign req_pc_inc = req_pc + INST_MEM_WIDTH'(1);
  assign imem_addr  = fetch_pc;

  // State register.
  always_ff @(posedge CLK) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and state-decoded strobes.
  always_comb begin
    state_nxt   = state;
    imem_en     = 1'b0;
    inst_enable = 1'b0;
    req_latch   = 1'b0;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        if (run) state_nxt = REQ;
      end
      REQ: begin
        imem_en   = 1'b1;
        req_latch = 1'b1;
        state_nxt = redirect_valid ? REQ : WAIT;
      end
      WAIT: begin
        if (redirect_valid) begin
          state_nxt = REQ;
        end else begin
          capture   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        inst_enable = 1'b1;
        if (redirect_valid)  state_nxt = REQ;
        else if (!stall_in)  state_nxt = run ? REQ : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Fetch pointer, epoch, in-flight request tag and the word shown to decode.
  always_ff @(posedge CLK) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      epoch     <= 1'b0;
      req_pc    <= '0;
      req_epoch <= 1'b0;
      inst      <= '0;
      pc        <= '0;
      pc1       <= '0;
      distinct  <= 1'b0;
    end else begin
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        epoch    <= ~epoch;
      end else if (capture) begin
        fetch_pc <= req_pc_inc;
      end
      if (req_latch) begin
        req_pc    <= fetch_pc;
        req_epoch <= epoch;
      end
      if (capture) begin
        inst     <= imem_rdata;
        pc       <= req_pc;
        pc1      <= req_pc_inc;
        distinct <= req_epoch;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios with literal expectations, then
// randomized run/stall/redirect/reset traffic against a fetch-age model.
module tb_inst_fetch;

  localparam int W     = 2;
  localparam int DEPTH = 1 << W;

  logic          CLK = 1'b0;
  logic          reset;
  logic          run;
  logic          stall_in;
  logic          redirect_valid;
  logic [W-1:0]  redirect_pc;
  logic          imem_en;
  logic [W-1:0]  imem_addr;
  logic [31:0]   imem_rdata;
  logic          inst_enable;
  logic [31:0]   inst;
  logic [W-1:0]  pc;
  logic [W-1:0]  pc1;
  logic          distinct;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [DEPTH];

  inst_fetch #(.INST_MEM_WIDTH(W), .RESET_PC(2'd0)) dut (
    .CLK(CLK), .reset(reset), .run(run), .stall_in(stall_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .inst_enable(inst_enable), .inst(inst), .pc(pc), .pc1(pc1),
    .distinct(distinct)
  );

  always #5 CLK = ~CLK;

  // Synchronous instruction memory, one cycle read latency.
  always @(posedge CLK) if (imem_en) imem_rdata <= mem[imem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a fetch is described only by its age in cycles since the request
  // (-1 = none, 0 = request cycle, 1 = data cycle, >=2 = visible to decode).
  bit          m_live = 0;
  int          m_age, m_fetch_pc, m_epoch, m_req_pc, m_req_ep;
  int          m_pc, m_pc1, m_dist;
  logic [31:0] m_inst;

  task automatic model_step();
    int old_fpc, old_ep;
    if (reset) begin
      m_live = 1; m_age = -1; m_fetch_pc = 0; m_epoch = 0;
      m_req_pc = 0; m_req_ep = 0; m_inst = 0; m_pc = 0; m_pc1 = 0; m_dist = 0;
      return;
    end
    if (!m_live) return;
    old_fpc = m_fetch_pc;
    old_ep  = m_epoch;
    if (redirect_valid) begin
      m_fetch_pc = int'(redirect_pc);
      m_epoch    = 1 - m_epoch;
    end
    if (m_age < 0) begin
      if (run) m_age = 0;
    end else if (m_age == 0) begin
      m_req_pc = old_fpc;
      m_req_ep = old_ep;
      m_age    = redirect_valid ? 0 : 1;
    end else if (m_age == 1) begin
      if (redirect_valid) m_age = 0;
      else begin
        m_inst     = mem[m_req_pc];
        m_pc       = m_req_pc;
        m_pc1      = (m_req_pc + 1) % DEPTH;
        m_dist     = m_req_ep;
        m_fetch_pc = (m_req_pc + 1) % DEPTH;
        m_age      = 2;
      end
    end else begin
      if (redirect_valid) m_age = 0;
      else if (stall_in)  m_age = m_age + 1;
      else                m_age = run ? 0 : -1;
    end
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge CLK);
    if (m_live) begin
      chk("imem_en",     32'(imem_en),     32'(m_age == 0));
      chk("imem_addr",   32'(imem_addr),   32'(m_fetch_pc));
      chk("inst_enable", 32'(inst_enable), 32'(m_age >= 2));
      chk("inst",        inst,             m_inst);
      chk("pc",          32'(pc),          32'(m_pc));
      chk("pc1",         32'(pc1),         32'(m_pc1));
      chk("distinct",    32'(distinct),    32'(m_dist));
    end
  end

  // Wait for the next presented word, check it literally, optionally stall
  // it and/or redirect in its issue cycle, then let it be consumed.
  task automatic issue_word(input logic [31:0] ei, input int ep, input int ed,
                            input int stall_n, input bit rd, input int rpc);
    bit found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge CLK);
      if (inst_enable === 1'b1) found = 1;
    end
    chk("issue_seen",     32'(found),    32'd1);
    chk("issue_inst",     inst,          ei);
    chk("issue_pc",       32'(pc),       32'(ep));
    chk("issue_pc1",      32'(pc1),      32'((ep + 1) % DEPTH));
    chk("issue_distinct", 32'(distinct), 32'(ed));
    if (stall_n > 0) begin
      stall_in = 1'b1;
      repeat (stall_n) begin
        @(negedge CLK);
        chk("stall_en",   32'(inst_enable), 32'd1);
        chk("stall_inst", inst,             ei);
        chk("stall_pc",   32'(pc),          32'(ep));
      end
      stall_in = 1'b0;
    end
    if (rd) begin
      redirect_valid = 1'b1;
      redirect_pc    = W'(rpc);
    end
    @(posedge CLK); #1;
    redirect_valid = 1'b0;
  endtask

  task automatic check_reset_outputs();
    @(negedge CLK);
    chk("rst_inst_enable", 32'(inst_enable), 32'd0);
    chk("rst_imem_en",     32'(imem_en),     32'd0);
    chk("rst_imem_addr",   32'(imem_addr),   32'd0);
    chk("rst_inst",        inst,             32'd0);
    chk("rst_pc",          32'(pc),          32'd0);
    chk("rst_pc1",         32'(pc1),         32'd0);
    chk("rst_distinct",    32'(distinct),    32'd0);
  endtask

  localparam logic [31:0] A = 32'hAAAA_0000;
  localparam logic [31:0] B = 32'hBBBB_0001;
  localparam logic [31:0] C = 32'hCCCC_0002;
  localparam logic [31:0] D = 32'hDDDD_0003;

  initial begin
    mem[0] = A; mem[1] = B; mem[2] = C; mem[3] = D;
    reset = 1'b1; run = 1'b0; stall_in = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge CLK);
    #1 reset = 1'b0;
    check_reset_outputs();

    // Straight-line fetch with wrap, then a 4-cycle stall on B.
    @(posedge CLK); #1 run = 1'b1;
    issue_word(A, 0, 0, 0, 0, 0);
    issue_word(B, 1, 0, 0, 0, 0);
    issue_word(C, 2, 0, 0, 0, 0);
    issue_word(D, 3, 0, 0, 0, 0);
    issue_word(A, 0, 0, 0, 0, 0);
    issue_word(B, 1, 0, 4, 0, 0);
    issue_word(C, 2, 0, 0, 0, 0);

    // Redirect to 3 while the read of pc1 is in its data cycle.
    reset = 1'b1;
    @(posedge CLK); #1 reset = 1'b0;
    issue_word(A, 0, 0, 0, 0, 0);
    @(posedge CLK); #1;
    redirect_valid = 1'b1; redirect_pc = 2'd3;
    @(posedge CLK); #1 redirect_valid = 1'b0;
    issue_word(D, 3, 1, 0, 0, 0);
    issue_word(A, 0, 1, 0, 0, 0);

    // Redirect to 2 during an unstalled issue of B.
    issue_word(B, 1, 1, 0, 1, 2);
    issue_word(C, 2, 0, 0, 0, 0);

    // Drop run in the request cycle of pc2.
    issue_word(D, 3, 0, 0, 0, 0);
    issue_word(A, 0, 0, 0, 0, 0);
    issue_word(B, 1, 0, 0, 0, 0);
    run = 1'b0;
    issue_word(C, 2, 0, 0, 0, 0);
    repeat (4) begin
      @(negedge CLK);
      chk("idle_imem_en",     32'(imem_en),     32'd0);
      chk("idle_inst_enable", 32'(inst_enable), 32'd0);
    end
    @(posedge CLK); #1 run = 1'b1;
    issue_word(D, 3, 0, 0, 0, 0);

    // Reset in the data cycle of pc0.
    @(posedge CLK); #1;
    reset = 1'b1; run = 1'b0;
    @(posedge CLK); #1 reset = 1'b0;
    check_reset_outputs();
    repeat (4) begin
      @(negedge CLK);
      chk("post_rst_quiet", 32'(inst_enable), 32'd0);
    end
    @(posedge CLK); #1 run = 1'b1;
    issue_word(A, 0, 0, 0, 0, 0);

    // Randomized traffic with fresh memory contents.
    @(posedge CLK); #1 reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    @(posedge CLK); #1 reset = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge CLK); #1;
      run            = ($urandom_range(0, 9) != 0);
      stall_in       = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = W'($urandom_range(0, DEPTH - 1));
      reset          = ($urandom_range(0, 199) == 0);
    end
    @(posedge CLK); #1;
    reset = 1'b0; run = 1'b0; stall_in = 1'b0; redirect_valid = 1'b0;
    repeat (3) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage, directly upstream of the instruction decode stage.
- Holds the program counter and issues reads to a synchronous instruction memory with 1-cycle read latency.
- Presents each fetched word to decode with a one-cycle inst_enable strobe, along with its pc, pc+1 and an epoch bit (distinct).
- Handles branch/jump redirects from the execute stage and decode back-pressure.

Parameters:
- INST_MEM_WIDTH, 2, width of the instruction address (pc, pc1, imem_addr, redirect_pc).
- RESET_PC, 0, pc value loaded on reset.

Ports:
- CLK  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- run  input  1  fetch enable; when low, no new fetch is started.
- stall_in  input  1  decode cannot accept this cycle (decode busy, i.e. not in its state 0).
- redirect_valid  input  1  taken branch/jump from execute.
- redirect_pc  input  INST_MEM_WIDTH  redirect target.
- imem_en  output  1  instruction memory read enable.
- imem_addr  output  INST_MEM_WIDTH  instruction memory read address.
- imem_rdata  input  32  read data, valid the cycle after imem_en.
- inst_enable  output  1  inst/pc/pc1/distinct are valid this cycle.
- inst  output  32  fetched instruction.
- pc  output  INST_MEM_WIDTH  address of inst.
- pc1  output  INST_MEM_WIDTH  pc+1, wrapping modulo 2^INST_MEM_WIDTH.
- distinct  output  1  epoch of inst; toggles on every redirect.

Behaviour:
- Reset (synchronous, active-high; overrides everything, including mid-fetch):
  - state=IDLE, fetch_pc=RESET_PC, epoch=0.
  - inst=0, pc=0, pc1=0, distinct=0.
  - inst_enable=0, imem_en=0, imem_addr=RESET_PC.
- States and transitions:
  - IDLE: outputs quiet. Goes to REQ when run=1.
  - REQ: imem_en=1, imem_addr=fetch_pc. Latches req_pc=fetch_pc and req_epoch=epoch. Goes to WAIT.
  - WAIT: at the end of the cycle, captures imem_rdata into inst, pc<=req_pc, pc1<=req_pc+1, distinct<=req_epoch, fetch_pc<=req_pc+1. Goes to ISSUE.
  - ISSUE: inst_enable=1, decoded from state (not a separate flop).
    - stall_in=1: hold; inst/pc/pc1/distinct stay stable.
    - stall_in=0: word is consumed at this edge; next state is REQ if run=1, else IDLE.
- Latency: 3 cycles per instruction with no stalls (REQ, WAIT, ISSUE). First inst_enable occurs 3 cycles after the edge that samples run=1 in IDLE.
- Redirect has priority over normal sequencing in every state:
  - On redirect: fetch_pc<=redirect_pc and epoch<=~epoch.
  - IDLE: stay IDLE (REQ if run=1).
  - REQ: the in-flight read is abandoned; next state is REQ with the new pc.
  - WAIT: imem_rdata is not captured and outputs are unchanged; next state is REQ.
  - ISSUE with stall_in=0: the visible word counts as consumed; next state is REQ.
  - ISSUE with stall_in=1: the held word is dropped without being consumed; next state is REQ.
  - inst_enable is never retracted combinationally. Decode discards wrong-path words by comparing distinct against the current epoch.
- run falling mid-fetch: the fetch in progress completes and issues; the block then returns to IDLE.
- Wrap: fetch_pc and pc1 wrap from 2^W-1 to 0 with no flag.
- Simultaneous redirect_valid and reset: reset wins.

Decomposition:
- Shared package cpu_pkg holds:
  - the fetch state enum (IDLE, REQ, WAIT, ISSUE) as a 2-bit typedef;
  - a typedef for the instruction word (32 bits);
  - a localparam for the memory read latency (1).
- No sub-module is needed; an instance of the existing instruction memory is connected at top level.

Test Plan:
- Reset, then run=1, stall_in=0, W=2, mem[0..3]=A,B,C,D → inst_enable pulses every 3rd cycle carrying A(pc0,pc1=1), B(1,2), C(2,3), D(3,0), then A again at pc0 (wrap); distinct=0 throughout.
- stall_in=1 held 4 cycles during ISSUE of B → inst_enable stays high 5 cycles with inst=B, pc=1 stable; next fetch is pc=2.
- redirect_valid=1, redirect_pc=3 during WAIT of pc1 → B is never issued; next issued word is D, pc=3, distinct=1.
- redirect_valid=1 during ISSUE with stall_in=0 → current word issues once; next word comes from redirect_pc and distinct toggles.
- run deasserted during REQ of pc2 → C issues, then the block sits in IDLE with imem_en=0; reasserting run fetches pc3.
- reset asserted during WAIT → next cycle all outputs are at reset values and no inst_enable occurs until run restarts fetch from RESET_PC.
